// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared size encodings, FSM state type and lane constants.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ls_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : ls_lane_align
// Purpose  : Little-endian lane extract/extend for loads, lane merge for stores.
// Revision : 1.0 - initial release
// ============================================================================
module ls_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_size,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte       = i_word[{i_lane, 3'b000} +: 8];
        w_half       = i_word[{i_lane[1], 4'b0000} +: 16];
        o_load_data  = '0;
        o_store_word = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{(DATA_W-8){w_byte[7] & ~i_unsigned}}, w_byte};
                o_store_word[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data = {{(DATA_W-16){w_half[15] & ~i_unsigned}}, w_half};
                o_store_word[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            SZ_WORD: begin
                o_load_data  = i_word;
                o_store_word = i_wdata;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store initiator with sub-word read-modify-write.
//            Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WORD_IDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_writeEn,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_rd
);

    state_t              r_state;
    state_t              w_next;
    logic [LANE_W-1:0]   r_lane;
    logic [1:0]          r_size;
    logic                r_we;
    logic                r_uns;
    logic                r_err;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rword;
    logic [ADDR_W-1:0]   r_mem_a;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_accept;
    logic                w_misalign;
    logic                w_err;
    logic                w_word_store;
    logic [ADDR_W-1:0]   w_addr_al;
    logic [ADDR_W-1:0]   w_widx;
    logic [DATA_W-1:0]   w_word_in;
    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_store;

    assign w_accept     = req_valid & (r_state == IDLE);
    assign w_word_store = req_we & (req_size == SZ_WORD);

    always_comb begin
        w_addr_al = req_addr;
        case (req_size)
            SZ_HALF: w_addr_al[0]   = 1'b0;
            SZ_WORD: w_addr_al[1:0] = 2'b00;
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (req_size == SZ_RSVD) | w_misalign;

    // Bits above the decoded index pass through untouched; the memory ignores them.
    assign w_widx = {2'b00, w_addr_al[ADDR_W-1:WORD_IDX_W+2], w_addr_al[WORD_IDX_W+1:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)             w_next = RESP;
                    else if (w_word_store) w_next = WR;
                    else                   w_next = RD;
                end
            end
            RD:      w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane      <= '0;
            r_size      <= '0;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_rword     <= '0;
            r_mem_a     <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_lane  <= w_addr_al[LANE_W-1:0];
                r_size  <= req_size;
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_err   <= w_err;
                r_wdata <= req_wdata;
                if (!w_err) r_mem_a <= w_widx;
                if (!w_err && w_word_store) r_mem_wdata <= req_wdata;
            end
            // Sub-word stores merge into the word fetched during RD.
            if (r_state == RD) begin
                r_rword <= mem_rd;
                if (r_we) r_mem_wdata <= w_store;
            end
        end
    end

    assign w_word_in = (r_state == RD) ? mem_rd : r_rword;

    ls_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane (
        .i_word       (w_word_in),
        .i_wdata      (r_wdata),
        .i_size       (r_size),
        .i_lane       (r_lane),
        .i_unsigned   (r_uns),
        .o_load_data  (w_load),
        .o_store_word (w_store)
    );

    assign req_ready     = (r_state == IDLE);
    assign stall         = (r_state != IDLE);
    assign mem_memRead   = (r_state == RD);
    assign mem_writeEn   = (r_state == WR);
    assign mem_a         = r_mem_a;
    assign mem_writedata = r_mem_wdata;
    assign resp_valid    = (r_state == RESP);
    assign resp_err      = (r_state == RESP) & r_err;
    assign resp_rdata    = ((r_state == RESP) && !r_we && !r_err) ? w_load : '0;

endmodule
`default_nettype wire
